// File: rtl/dpm_ustk_if.sv
// -----------------------------------------------------------------------------
// dpm_ustk_if - micro-stack bus between the microsequencer (MSQ) and the
// DPM micro-stack storage.
//
// Signals:
//   push_h        push request (JSR / microvector taken)
//   ustk_out_en_l active-low return cycle; pop request when low
//   ret_addr_h    return address to save on push
//   ustk_addr_h   sequencer's next stack pointer (sync check)
//   ustk_h        top of stack driven back during return cycles (wired-OR)
//
// Modports:
//   master - sequencer side (drives requests, receives ustk_h)
//   slave  - stack storage side
// -----------------------------------------------------------------------------
interface dpm_ustk_if #(
  parameter int AW = 4,
  parameter int DW = 6
);
  logic          push_h;
  logic          ustk_out_en_l;
  logic [DW-1:0] ret_addr_h;
  logic [AW-1:0] ustk_addr_h;
  logic [DW-1:0] ustk_h;

  modport master (
    output push_h,
    output ustk_out_en_l,
    output ret_addr_h,
    output ustk_addr_h,
    input  ustk_h
  );

  modport slave (
    input  push_h,
    input  ustk_out_en_l,
    input  ret_addr_h,
    input  ustk_addr_h,
    output ustk_h
  );
endinterface

// File: rtl/dpm_ustk.sv
// -----------------------------------------------------------------------------
// dpm_ustk - micro-stack storage for the microsequencer.
//
// Holds return addresses pushed on JSR/microvector cycles and drives the top
// of stack back onto the ustk bus during return cycles. Keeps a shadow stack
// pointer and a live depth count, and raises sticky overflow, underflow and
// pointer-desync flags.
//
// Ports:
//   mclk_l      microcycle clock, state updates on rising edge
//   init_h      asynchronous active-high reset
//   bus         dpm_ustk_if.slave (push_h, ustk_out_en_l, ret_addr_h,
//               ustk_addr_h in; ustk_h out)
//   diag_sel_h  diagnostic read index
//   diag_data_h combinational mem[diag_sel_h]
//   depth_h     live entry count, 0..2**AW
//   ovf_h       sticky overflow flag
//   unf_h       sticky underflow flag
//   sync_err_h  sticky pointer desync flag
// -----------------------------------------------------------------------------
module dpm_ustk #(
  parameter int AW = 4,
  parameter int DW = 6
) (
  input  logic          mclk_l,
  input  logic          init_h,
  dpm_ustk_if.slave     bus,
  input  logic [AW-1:0] diag_sel_h,
  output logic [DW-1:0] diag_data_h,
  output logic [AW:0]   depth_h,
  output logic          ovf_h,
  output logic          unf_h,
  output logic          sync_err_h
);

  localparam int          NENT = 2 ** AW;
  localparam logic [AW:0] FULL = (AW + 1)'(NENT);

  logic [DW-1:0] r_mem [NENT];
  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_depth;
  logic [DW-1:0] r_tos;
  logic          r_ovf;
  logic          r_unf;
  logic          r_sync_err;

  logic          w_push;
  logic          w_pop;
  logic [AW-1:0] w_ptr_nxt;

  // Push wins over a simultaneous return enable, matching the sequencer.
  assign w_push = bus.push_h;
  assign w_pop  = ~bus.ustk_out_en_l & ~bus.push_h;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_push)     w_ptr_nxt = r_ptr + 1'b1;
    else if (w_pop) w_ptr_nxt = r_ptr - 1'b1;
  end

  // NOTE: storage array is deliberately left out of reset; only the pointer,
  // depth and flags define the stack state, so contents after init are don't-care.
  // The write is suppressed while init_h is held so a push coinciding with reset
  // is discarded.
  always_ff @(posedge mclk_l) begin
    if (w_push && !init_h) r_mem[w_ptr_nxt] <= bus.ret_addr_h;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers
  // sample the pre-edge values (e.g. the pop reads mem before any write lands).
  always_ff @(posedge mclk_l or posedge init_h) begin
    if (init_h) begin
      r_ptr      <= '0;
      r_depth    <= '0;
      r_tos      <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_sync_err <= 1'b0;
    end else begin
      if (w_push) begin
        r_ptr <= w_ptr_nxt;
        r_tos <= bus.ret_addr_h;
        // A full stack wraps onto its oldest entry; depth saturates.
        if (r_depth == FULL) r_ovf   <= 1'b1;
        else                 r_depth <= r_depth + 1'b1;
      end else if (w_pop) begin
        r_ptr <= w_ptr_nxt;
        r_tos <= r_mem[w_ptr_nxt];
        // An empty pop still moves the pointer so the shadow tracks the MSQ.
        if (r_depth == '0) r_unf   <= 1'b1;
        else               r_depth <= r_depth - 1'b1;
      end

      if ((w_push || w_pop) && (bus.ustk_addr_h != w_ptr_nxt))
        r_sync_err <= 1'b1;
    end
  end

  // Zero-latency return path; all-zero when not returning so the bus can be OR-ed.
  assign bus.ustk_h  = bus.ustk_out_en_l ? '0 : r_tos;
  assign diag_data_h = r_mem[diag_sel_h];
  assign depth_h     = r_depth;
  assign ovf_h       = r_ovf;
  assign unf_h       = r_unf;
  assign sync_err_h  = r_sync_err;

endmodule

// File: tb/tb_dpm_ustk.sv
// -----------------------------------------------------------------------------
// tb_dpm_ustk - self-checking bench for dpm_ustk.
// A behavioural stack (SV queue, oldest entry at the front) predicts depth,
// top of stack and flags; expected return-bus values are queued when a return
// cycle is driven and popped when the bus is sampled.
// -----------------------------------------------------------------------------
module tb_dpm_ustk;
  localparam int AW = 4;
  localparam int DW = 6;
  localparam int NENT = 2 ** AW;

  logic          mclk_l = 1'b0;
  logic          init_h;
  logic [AW-1:0] diag_sel_h;
  logic [DW-1:0] diag_data_h;
  logic [AW:0]   depth_h;
  logic          ovf_h, unf_h, sync_err_h;

  dpm_ustk_if #(.AW(AW), .DW(DW)) bus ();

  dpm_ustk #(.AW(AW), .DW(DW)) dut (
    .mclk_l      (mclk_l),
    .init_h      (init_h),
    .bus         (bus.slave),
    .diag_sel_h  (diag_sel_h),
    .diag_data_h (diag_data_h),
    .depth_h     (depth_h),
    .ovf_h       (ovf_h),
    .unf_h       (unf_h),
    .sync_err_h  (sync_err_h)
  );

  always #5 mclk_l = ~mclk_l;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int       m_stk[$];
  int       m_ptr;
  int       m_tos;
  bit       m_tos_known;
  bit       m_ovf, m_unf, m_sync;
  int       exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_stk.delete();
    m_ptr = 0; m_tos = 0; m_tos_known = 1'b1;
    m_ovf = 1'b0; m_unf = 1'b0; m_sync = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge mclk_l);
    init_h = 1'b1;
    bus.push_h = 1'b0; bus.ustk_out_en_l = 1'b1;
    bus.ret_addr_h = '0; bus.ustk_addr_h = '0;
    model_reset();
    @(negedge mclk_l);
    init_h = 1'b0;
  endtask

  // One microcycle: drive at the falling edge, check the return bus inside the
  // cycle, clock, then check the registered state. addr_ovr < 0 means present
  // the pointer the model expects.
  task automatic step(input bit push, input bit ret, input logic [DW-1:0] val,
                      input int addr_ovr = -1);
    bit pop;
    int nptr;
    int addr;
    pop  = ret && !push;
    nptr = push ? (m_ptr + 1) % NENT : pop ? (m_ptr + NENT - 1) % NENT : m_ptr;
    addr = (addr_ovr >= 0) ? addr_ovr : nptr;
    @(negedge mclk_l);
    bus.push_h        = push;
    bus.ustk_out_en_l = ~ret;
    bus.ret_addr_h    = val;
    bus.ustk_addr_h   = AW'(addr);
    if (ret && m_tos_known) exp_q.push_back(m_tos);
    #1;
    if (ret && m_tos_known) check("ustk_ret", 32'(bus.ustk_h), 32'(exp_q.pop_front()));
    if (!ret) check("ustk_idle", 32'(bus.ustk_h), 32'd0);
    // Model update for the coming edge.
    if (push) begin
      if (m_stk.size() == NENT) begin
        void'(m_stk.pop_front());
        m_ovf = 1'b1;
      end
      m_stk.push_back(int'(val));
      m_tos = int'(val); m_tos_known = 1'b1;
    end else if (pop) begin
      if (m_stk.size() == 0) begin
        m_unf = 1'b1;
        m_tos_known = 1'b0;
      end else begin
        void'(m_stk.pop_back());
        if (m_stk.size() > 0) m_tos = m_stk[$];
        else m_tos_known = 1'b0;
      end
    end
    if ((push || pop) && addr != nptr) m_sync = 1'b1;
    m_ptr = nptr;
    @(posedge mclk_l);
    #1;
    check("depth", 32'(depth_h), 32'(m_stk.size()));
    check("ovf",   32'(ovf_h),   32'(m_ovf));
    check("unf",   32'(unf_h),   32'(m_unf));
    check("sync",  32'(sync_err_h), 32'(m_sync));
  endtask

  task automatic idle();
    @(negedge mclk_l);
    bus.push_h = 1'b0; bus.ustk_out_en_l = 1'b1;
  endtask

  initial begin
    init_h = 1'b1;
    diag_sel_h = '0;
    bus.push_h = 1'b0; bus.ustk_out_en_l = 1'b1;
    bus.ret_addr_h = '0; bus.ustk_addr_h = '0;
    model_reset();

    // Reset state.
    do_reset();
    #1;
    check("rst_depth", 32'(depth_h), 32'd0);
    check("rst_ovf", 32'(ovf_h), 32'd0);
    check("rst_unf", 32'(unf_h), 32'd0);
    check("rst_sync", 32'(sync_err_h), 32'd0);
    check("rst_ustk", 32'(bus.ustk_h), 32'd0);

    // Three pushes, then two return cycles.
    step(1, 0, 6'h11);
    step(1, 0, 6'h22);
    step(1, 0, 6'h33);
    check("three_depth", 32'(depth_h), 32'd3);
    step(0, 1, 6'h00);                       // shows 0x33, pops
    check("after_pop_depth", 32'(depth_h), 32'd2);
    step(0, 1, 6'h00);                       // shows 0x22
    idle();

    // Overflow: 17 pushes of 1..17, then 16 returns showing 17..2.
    do_reset();
    for (int i = 1; i <= 17; i++) step(1, 0, DW'(i));
    check("ovf_set", 32'(ovf_h), 32'd1);
    check("ovf_depth", 32'(depth_h), 32'd16);
    for (int i = 0; i < 16; i++) step(0, 1, 6'h00);
    check("drain_depth", 32'(depth_h), 32'd0);
    idle();

    // Underflow after reset; pointer wraps to 15, next push must present 0.
    do_reset();
    step(0, 1, 6'h00);
    check("unf_set", 32'(unf_h), 32'd1);
    check("unf_depth", 32'(depth_h), 32'd0);
    step(1, 0, 6'h05, 0);
    check("wrap_sync", 32'(sync_err_h), 32'd0);
    diag_sel_h = 4'd0;
    #1 check("diag_wrap", 32'(diag_data_h), 32'h05);

    // Push with return enable in the same cycle: push only, bus shows old tos.
    step(1, 1, 6'h2A);
    check("pr_depth", 32'(depth_h), 32'd2);
    check("pr_newtos", 32'(bus.ustk_h), 32'h2A);
    idle();

    // Desync: pointer 1 expected, sequencer presents 5; flag stays sticky.
    do_reset();
    step(1, 0, 6'h07, 5);
    check("desync_set", 32'(sync_err_h), 32'd1);
    step(1, 0, 6'h08);
    check("desync_sticky", 32'(sync_err_h), 32'd1);

    // Asynchronous reset between edges.
    @(posedge mclk_l);
    #3;
    init_h = 1'b1;
    bus.push_h = 1'b0;
    bus.ustk_out_en_l = 1'b0;
    diag_sel_h = 4'd1;
    #1;
    check("arst_depth", 32'(depth_h), 32'd0);
    check("arst_ovf", 32'(ovf_h), 32'd0);
    check("arst_unf", 32'(unf_h), 32'd0);
    check("arst_sync", 32'(sync_err_h), 32'd0);
    check("arst_ustk", 32'(bus.ustk_h), 32'd0);
    check("arst_diag", 32'(diag_data_h), 32'h07);
    bus.ustk_out_en_l = 1'b1;
    model_reset();
    @(negedge mclk_l);
    init_h = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Hard time limit so the bench can never hang.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end
endmodule
